// File: rtl/verin_pkg.sv
// Shared definitions for the vérin angle-sensor ADC acquisition path.
//   ADC_BITS       : native conversion width of the ADC0831-style converter
//   ADC_PRE_PULSES : clk_adc pulses issued before the first data bit
//   acq_state_t    : acquisition sequencer states
`timescale 1ns/1ps
package verin_pkg;

  localparam int unsigned ADC_BITS       = 8;
  localparam int unsigned ADC_PRE_PULSES = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CLOCKING,
    GAP
  } acq_state_t;

endpackage

// File: rtl/verin_adc_clkgen.sv
// ADC serial clock generator: divides clk into clk_adc half-periods of CLK_DIV
// cycles while run is high, and flags the edges to the acquisition sequencer.
//   clk, reset_n  : system clock, synchronous active-low reset
//   run           : counter enable; low forces phase 0 and clk_adc low
//   clk_adc       : registered ADC serial clock
//   rise_tick_c   : this cycle ends a low half-period (clk_adc rises next)
//   fall_tick_c   : this cycle ends a high half-period (clk_adc falls next)
//   sample_tick_c : last cycle of a high half-period (serial data sample point)
`timescale 1ns/1ps
module verin_adc_clkgen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic clk_adc,
  output logic rise_tick_c,
  output logic fall_tick_c,
  output logic sample_tick_c
);

  localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            clk_adc_q, clk_adc_d;
  logic            wrap_c;

  // Phase counter and half-period toggle
  always_comb begin
    phase_d       = phase_q;
    clk_adc_d     = clk_adc_q;
    wrap_c        = (phase_q == PH_W'(CLK_DIV - 1));
    rise_tick_c   = run && wrap_c && !clk_adc_q;
    fall_tick_c   = run && wrap_c && clk_adc_q;
    sample_tick_c = run && wrap_c && clk_adc_q;
    if (!run) begin
      phase_d   = '0;
      clk_adc_d = 1'b0;
    end else if (wrap_c) begin
      phase_d   = '0;
      clk_adc_d = ~clk_adc_q;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q   <= '0;
      clk_adc_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      clk_adc_q <= clk_adc_d;
    end
  end

  assign clk_adc = clk_adc_q;

endmodule

// File: rtl/verin_adc_acq.sv
// Serial acquisition front-end for the vérin angle sensor ADC. Frames the
// converter with cs_n/clk_adc, shifts data_in in MSB first after the mux-settle
// pulse, and publishes each conversion on data_out with a one-cycle data_valid.
//   clk, reset_n : system clock, synchronous active-low reset
//   enable       : back-to-back frames while high
//   start        : single-shot request, only honoured when idle
//   data_in      : asynchronous ADC serial data
//   clk_adc      : ADC serial clock
//   cs_n         : ADC chip select, active low
//   data_out     : last completed conversion
//   data_valid   : one-cycle pulse when data_out updates
//   busy         : high from frame launch until back in IDLE
`timescale 1ns/1ps
module verin_adc_acq
  import verin_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 50,
  parameter int unsigned DATA_W     = ADC_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              data_in,
  output logic              clk_adc,
  output logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned PRE_W = $clog2(ADC_PRE_PULSES + 1);

  acq_state_t        state_q, state_d;
  logic              din_s1_q, din_s_q;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;

  logic              run_c;
  logic              rise_tick_c, fall_tick_c, sample_tick_c;
  logic [DATA_W-1:0] shifted_c;

  assign run_c     = (state_q == SETUP) || (state_q == CLOCKING);
  assign shifted_c = {sr_q[DATA_W-2:0], din_s_q};

  verin_adc_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run_c),
    .clk_adc       (clk_adc),
    .rise_tick_c   (rise_tick_c),
    .fall_tick_c   (fall_tick_c),
    .sample_tick_c (sample_tick_c)
  );

  // Frame sequencer; the END edge is the final sample tick leaving CLOCKING
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    pre_cnt_d    = pre_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sr_d         = sr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (start || enable) begin
          state_d   = SETUP;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          pre_cnt_d = '0;
          sr_d      = '0;
        end
      end
      SETUP: begin
        if (rise_tick_c) state_d = CLOCKING;
      end
      CLOCKING: begin
        // Pre-pulses let the input mux settle; they carry no data bit
        if (fall_tick_c && (pre_cnt_q != PRE_W'(ADC_PRE_PULSES))) begin
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end else if (sample_tick_c) begin
          sr_d = shifted_c;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            data_out_d   = shifted_c;
            data_valid_d = 1'b1;
            cs_n_d       = 1'b1;
            gap_cnt_d    = '0;
            state_d      = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          // Continuous mode relaunches straight from GAP without an IDLE cycle
          if (enable) begin
            state_d   = SETUP;
            cs_n_d    = 1'b0;
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            sr_d      = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      din_s1_q     <= 1'b0;
      din_s_q      <= 1'b0;
      bit_cnt_q    <= '0;
      pre_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sr_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_s1_q     <= data_in;
      din_s_q      <= din_s1_q;
      bit_cnt_q    <= bit_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sr_q         <= sr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_verin_adc_acq.sv
// Directed bench for verin_adc_acq with a behavioural ADC0831 serial model.
`timescale 1ns/1ps
module tb_verin_adc_acq;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 5;
  localparam int unsigned DATA_W     = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              start = 1'b0;
  logic              data_in;
  logic              clk_adc;
  logic              cs_n;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  verin_adc_acq #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .DATA_W     (DATA_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .data_in    (data_in),
    .clk_adc    (clk_adc),
    .cs_n       (cs_n),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  // ADC model: pulse 1 drives a decoy bit, pulses 2..9 present bits 7..0
  logic       tog = 1'b0;
  logic       use_tog = 1'b0;
  logic       model_bit = 1'b0;
  logic [7:0] adc_word = 8'h00;
  logic [7:0] word_q[$];
  int         pulse_n = 0;

  assign data_in = use_tog ? tog : model_bit;

  always @(negedge cs_n) begin
    pulse_n = 0;
    if (word_q.size() > 0) adc_word = word_q.pop_front();
  end

  always @(posedge clk_adc) begin
    pulse_n++;
    if (pulse_n == 1) model_bit = ~adc_word[7];
    else if (pulse_n <= 9) model_bit = adc_word[3'(9 - pulse_n)];
  end

  // Observation counters, sampled on the falling clock edge
  int         cs_low, rises, cs_falls, dv_cnt, hi_run, busy_fall_cyc;
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];
  int         hi_runs[$];
  logic       adc_prev = 1'b0, cs_prev = 1'b1, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!cs_n) cs_low++;
    if (clk_adc && !adc_prev) rises++;
    adc_prev = clk_adc;
    if (cs_n) hi_run++;
    else begin
      if (cs_prev) begin
        hi_runs.push_back(hi_run);
        cs_falls++;
      end
      hi_run = 0;
    end
    cs_prev = cs_n;
    if (data_valid) begin
      dv_cnt++;
      dv_cyc.push_back(cyc);
      dv_dat.push_back(data_out);
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic clear_stats();
    cs_low = 0; rises = 0; cs_falls = 0; dv_cnt = 0; hi_run = 0;
    busy_fall_cyc = -1;
    dv_cyc.delete(); dv_dat.delete(); hi_runs.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic launch_start(output int lc);
    @(posedge clk); #1;
    start = 1'b1;
    lc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_dv(input int n, input int max, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < max) begin
      @(posedge clk); #1;
      if (dv_cnt >= n) ok = 1'b1;
      i++;
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < max) begin
      @(posedge clk); #1;
      if (!busy) ok = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    use_tog = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tog = ~tog;
      got = {cs_n, clk_adc, data_out, data_valid, busy};
      vectors++;
      if (got !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %03h expected %03h", i, got, 12'h800);
      end
    end
    reset_n = 1'b1;
    use_tog = 1'b0;
    step(2);
  endtask

  task automatic test_reset_midframe();
    int lc;
    bit ok;
    logic [11:0] got;
    word_q.push_back(8'hC3);
    clear_stats();
    launch_start(lc);
    while (cyc < lc + 40) step(1);
    vectors++;
    if ({cs_n, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_inframe: got cs_n/busy %b expected 01", {cs_n, busy});
    end
    reset_n = 1'b0;
    step(1);
    got = {cs_n, clk_adc, data_out, data_valid, busy};
    vectors++;
    if (got !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_abort: got %03h expected %03h", got, 12'h800);
    end
    reset_n = 1'b1;
    step(20);
    vectors++;
    if (dv_cnt !== 0 || cs_n !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_quiet: got dv %0d cs_n %b busy %b expected dv 0 cs_n 1 busy 0",
               dv_cnt, cs_n, busy);
    end
    // A fresh single shot after the abort must produce a complete frame
    word_q.push_back(8'h5A);
    clear_stats();
    launch_start(lc);
    wait_dv(1, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_relaunch_timeout: got no data_valid expected 1");
    end
    wait_idle(50, ok);
    vectors++;
    if (dv_cnt !== 1 || data_out !== 8'h5A || cs_low !== 72) begin
      miscompares++;
      $display("FAIL midrst_relaunch: got dv %0d data %02h cs_low %0d expected dv 1 data 5a cs_low 72",
               dv_cnt, data_out, cs_low);
    end
  endtask

  task automatic test_single();
    int lc;
    bit ok;
    word_q.push_back(8'hA5);
    clear_stats();
    launch_start(lc);
    wait_dv(1, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_timeout: got no data_valid expected 1");
    end
    wait_idle(50, ok);
    step(10);
    vectors++;
    if (cs_low !== 72) begin
      miscompares++;
      $display("FAIL single_cs_low: got %0d expected 72", cs_low);
    end
    vectors++;
    if (rises !== 9) begin
      miscompares++;
      $display("FAIL single_rises: got %0d expected 9", rises);
    end
    vectors++;
    if (dv_cnt !== 1) begin
      miscompares++;
      $display("FAIL single_dv_count: got %0d expected 1", dv_cnt);
    end
    if (dv_cyc.size() > 0) begin
      vectors++;
      if (dv_cyc[0] - lc !== 73) begin
        miscompares++;
        $display("FAIL single_dv_latency: got %0d expected 73", dv_cyc[0] - lc);
      end
      vectors++;
      if (busy_fall_cyc - dv_cyc[0] !== 5) begin
        miscompares++;
        $display("FAIL single_gap_idle: got %0d expected 5", busy_fall_cyc - dv_cyc[0]);
      end
    end
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_data: got %02h expected a5", data_out);
    end
  endtask

  task automatic test_continuous();
    int lc;
    bit ok;
    logic [7:0] exp_w[3];
    exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h3C;
    for (int i = 0; i < 3; i++) word_q.push_back(exp_w[i]);
    clear_stats();
    @(posedge clk); #1;
    enable = 1'b1;
    lc = cyc;
    wait_dv(3, 400, ok);
    enable = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cont_timeout: got %0d pulses expected 3", dv_cnt);
    end
    wait_idle(50, ok);
    step(20);
    vectors++;
    if (dv_cnt !== 3 || cs_falls !== 3 || rises !== 27 || cs_low !== 216) begin
      miscompares++;
      $display("FAIL cont_counts: got dv %0d falls %0d rises %0d cs_low %0d expected 3 3 27 216",
               dv_cnt, cs_falls, rises, cs_low);
    end
    if (dv_cyc.size() == 3) begin
      vectors++;
      if (dv_cyc[0] - lc !== 73) begin
        miscompares++;
        $display("FAIL cont_first_latency: got %0d expected 73", dv_cyc[0] - lc);
      end
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (dv_cyc[i] - dv_cyc[i-1] !== 77) begin
          miscompares++;
          $display("FAIL cont_spacing[%0d]: got %0d expected 77", i, dv_cyc[i] - dv_cyc[i-1]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (dv_dat[i] !== exp_w[i]) begin
          miscompares++;
          $display("FAIL cont_data[%0d]: got %02h expected %02h", i, dv_dat[i], exp_w[i]);
        end
      end
    end
    if (hi_runs.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (hi_runs[i] !== 5) begin
          miscompares++;
          $display("FAIL cont_cs_gap[%0d]: got %0d expected 5", i, hi_runs[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int lc;
    bit ok;
    word_q.push_back(8'h69);
    clear_stats();
    launch_start(lc);
    while (cyc < lc + 30) step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_dv(1, 200, ok);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle(50, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL busy_start_timeout: got busy %b expected 0", busy);
    end
    step(100);
    vectors++;
    if (cs_falls !== 1 || dv_cnt !== 1 || data_out !== 8'h69) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got falls %0d dv %0d data %02h expected 1 1 69",
               cs_falls, dv_cnt, data_out);
    end
    if (dv_cyc.size() > 0) begin
      vectors++;
      if (busy_fall_cyc - dv_cyc[0] !== 5) begin
        miscompares++;
        $display("FAIL busy_start_gap: got %0d expected 5", busy_fall_cyc - dv_cyc[0]);
      end
    end
  endtask

  task automatic test_enable_drop();
    int lc;
    bit ok;
    word_q.push_back(8'h81);
    clear_stats();
    @(posedge clk); #1;
    enable = 1'b1;
    lc = cyc;
    while (cyc < lc + 30) step(1);
    enable = 1'b0;
    wait_dv(1, 200, ok);
    wait_idle(50, ok);
    step(60);
    vectors++;
    if (dv_cnt !== 1 || data_out !== 8'h81) begin
      miscompares++;
      $display("FAIL endrop_data: got dv %0d data %02h expected 1 81", dv_cnt, data_out);
    end
    vectors++;
    if (cs_falls !== 1 || busy !== 1'b0 || cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL endrop_idle: got falls %0d busy %b cs_n %b expected 1 0 1",
               cs_falls, busy, cs_n);
    end
    if (dv_cyc.size() > 0) begin
      vectors++;
      if (dv_cyc[0] - lc !== 73 || busy_fall_cyc - dv_cyc[0] !== 5) begin
        miscompares++;
        $display("FAIL endrop_timing: got latency %0d gap %0d expected 73 5",
                 dv_cyc[0] - lc, busy_fall_cyc - dv_cyc[0]);
      end
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_reset_midframe();
    test_single();
    test_continuous();
    test_start_ignored();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
